// File: rtl/wheel_pkg.sv
// Shared definitions for the wheel state buffer slice.
//   - state_t        : update sequencer states (IDLE / RUN / COMMIT)
//   - DEF_*          : default array geometry and field widths
//   - IDX_X / IDX_Y  : first index of every [2][N] position/velocity array
package wheel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int DEF_NUM_NODES     = 10;
    localparam int DEF_POSITION_SIZE = 18;
    localparam int DEF_VELOCITY_SIZE = 8;
    localparam int DEF_DROP_BITS     = 8;

    localparam int IDX_X = 0;
    localparam int IDX_Y = 1;

endpackage

// File: rtl/wheel_state_buffer_if.sv
// Bundle of all non-clock/reset signals between the frame/update_wheel side
// and wheel_state_buffer.
//   master : the environment (frame timing, update_wheel streams, render)
//   slave  : wheel_state_buffer
interface wheel_state_buffer_if
    import wheel_pkg::*;
#(
    parameter int NUM_NODES     = DEF_NUM_NODES,
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int DROP_BITS     = DEF_DROP_BITS
) ();

    logic                                            frame_in;
    logic                                            load_in;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    init_nodes_in;
    logic [POSITION_SIZE-1:0]                        node_x_in;
    logic [POSITION_SIZE-1:0]                        node_y_in;
    logic                                            node_valid_in;
    logic [VELOCITY_SIZE-1:0]                        vel_x_in;
    logic [VELOCITY_SIZE-1:0]                        vel_y_in;
    logic                                            vel_valid_in;
    logic                                            result_in;
    logic                                            begin_out;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    nodes_out;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]    velocities_out;
    logic                                            busy_out;
    logic                                            commit_out;
    logic                                            error_out;
    logic [DROP_BITS-1:0]                            drop_count_out;

    modport master (
        output frame_in, load_in, init_nodes_in,
               node_x_in, node_y_in, node_valid_in,
               vel_x_in, vel_y_in, vel_valid_in, result_in,
        input  begin_out, nodes_out, velocities_out,
               busy_out, commit_out, error_out, drop_count_out
    );

    modport slave (
        input  frame_in, load_in, init_nodes_in,
               node_x_in, node_y_in, node_valid_in,
               vel_x_in, vel_y_in, vel_valid_in, result_in,
        output begin_out, nodes_out, velocities_out,
               busy_out, commit_out, error_out, drop_count_out
    );

endinterface

// File: rtl/wheel_state_buffer_stream_collector.sv
// stream_collector: captures a stream of (x, y) beats into a 2 x DEPTH shadow
// array at an incrementing write pointer.
//   clr_in        : zero the pointer and overflow flag (shadow data kept)
//   en_in         : beats are only accepted while enabled
//   valid_in/x/y  : beat
//   cnt_nx_out    : pointer value after this cycle (includes a same-cycle beat)
//   ovf_nx_out    : overflow flag after this cycle
//   data_out      : registered shadow array, [0] = x, [1] = y
module stream_collector
    import wheel_pkg::*;
#(
    parameter int DEPTH = DEF_NUM_NODES,
    parameter int WIDTH = DEF_POSITION_SIZE,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 clr_in,
    input  logic                                 en_in,
    input  logic                                 valid_in,
    input  logic [WIDTH-1:0]                     x_in,
    input  logic [WIDTH-1:0]                     y_in,
    output logic [CW-1:0]                        cnt_nx_out,
    output logic                                 ovf_nx_out,
    output logic [1:0][DEPTH-1:0][WIDTH-1:0]     data_out
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]                    cnt_q, cnt_d;
    logic                             ovf_q, ovf_d;
    logic [1:0][DEPTH-1:0][WIDTH-1:0] data_q, data_d;

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        data_d = data_q;
        if (clr_in) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_in && valid_in) begin
            // A beat past the last node is dropped but poisons the update.
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                data_d[IDX_X][cnt_q] = x_in;
                data_d[IDX_Y][cnt_q] = y_in;
                cnt_d                = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            data_q <= data_d;
        end
    end

    assign cnt_nx_out = cnt_d;
    assign ovf_nx_out = ovf_d;
    assign data_out   = data_q;

endmodule

// File: rtl/wheel_state_buffer.sv
// wheel_state_buffer: issues one begin pulse per frame to update_wheel,
// collects its position/velocity beat streams into shadow arrays and commits
// them atomically to the live arrays only when an update is complete and
// clean. Incomplete/overlong updates set a sticky error and leave live data.
//   clk_in / rst_in : clock, async active-low reset
//   bus (slave)     : frame/load/init inputs, beat streams, result pulse,
//                     begin pulse, live arrays, busy/commit/error, drop count
module wheel_state_buffer
    import wheel_pkg::*;
#(
    parameter int NUM_NODES     = DEF_NUM_NODES,
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int DROP_BITS     = DEF_DROP_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    wheel_state_buffer_if.slave   bus
);

    localparam int            CW   = $clog2(NUM_NODES + 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_NODES);

    state_t                                          state_q, state_d;
    logic                                            pending_q, pending_d;
    logic                                            begin_q, begin_d;
    logic                                            commit_q, commit_d;
    logic                                            error_q, error_d;
    logic [DROP_BITS-1:0]                            drop_q, drop_d;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    pos_q, pos_d;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]    vel_q, vel_d;

    logic                                            start;
    logic                                            clr;
    logic                                            run_en;
    logic [CW-1:0]                                   pos_cnt_nx, vel_cnt_nx;
    logic                                            pos_ovf_nx, vel_ovf_nx;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]    pos_shadow;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]    vel_shadow;

    assign start  = (state_q == ST_IDLE) && (bus.frame_in || pending_q);
    assign clr    = bus.load_in || start;
    assign run_en = (state_q == ST_RUN) && !bus.load_in;

    stream_collector #(.DEPTH(NUM_NODES), .WIDTH(POSITION_SIZE), .CW(CW)) u_pos (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clr_in     (clr),
        .en_in      (run_en),
        .valid_in   (bus.node_valid_in),
        .x_in       (bus.node_x_in),
        .y_in       (bus.node_y_in),
        .cnt_nx_out (pos_cnt_nx),
        .ovf_nx_out (pos_ovf_nx),
        .data_out   (pos_shadow)
    );

    stream_collector #(.DEPTH(NUM_NODES), .WIDTH(VELOCITY_SIZE), .CW(CW)) u_vel (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clr_in     (clr),
        .en_in      (run_en),
        .valid_in   (bus.vel_valid_in),
        .x_in       (bus.vel_x_in),
        .y_in       (bus.vel_y_in),
        .cnt_nx_out (vel_cnt_nx),
        .ovf_nx_out (vel_ovf_nx),
        .data_out   (vel_shadow)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        begin_d   = 1'b0;
        commit_d  = 1'b0;
        error_d   = error_q;
        drop_d    = drop_q;
        pos_d     = pos_q;
        vel_d     = vel_q;

        // One-deep frame buffer while an update is in flight; extras are counted.
        if (bus.frame_in && state_q != ST_IDLE) begin
            if (!pending_q)
                pending_d = 1'b1;
            else if (drop_q != '1)
                drop_d = drop_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    begin_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counts used here already include any beat valid this cycle.
                if (bus.result_in) begin
                    if (pos_cnt_nx == FULL && vel_cnt_nx == FULL &&
                        !pos_ovf_nx && !vel_ovf_nx) begin
                        state_d = ST_COMMIT;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                pos_d    = pos_shadow;
                vel_d    = vel_shadow;
                commit_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Load aborts any update; a coincident frame is kept as pending.
        if (bus.load_in) begin
            pos_d     = bus.init_nodes_in;
            vel_d     = '0;
            state_d   = ST_IDLE;
            pending_d = bus.frame_in;
            begin_d   = 1'b0;
            commit_d  = 1'b0;
            error_d   = error_q;
            drop_d    = drop_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            begin_q   <= 1'b0;
            commit_q  <= 1'b0;
            error_q   <= 1'b0;
            drop_q    <= '0;
            pos_q     <= '0;
            vel_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            begin_q   <= begin_d;
            commit_q  <= commit_d;
            error_q   <= error_d;
            drop_q    <= drop_d;
            pos_q     <= pos_d;
            vel_q     <= vel_d;
        end
    end

    assign bus.begin_out      = begin_q;
    assign bus.commit_out     = commit_q;
    assign bus.error_out      = error_q;
    assign bus.drop_count_out = drop_q;
    assign bus.nodes_out      = pos_q;
    assign bus.velocities_out = vel_q;
    assign bus.busy_out       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wheel_state_buffer.sv
// Directed bench for wheel_state_buffer: normal commit, short update,
// overflow, same-cycle last beat with result, frames while busy, load abort
// and asynchronous reset in COMMIT.
module tb_wheel_state_buffer;
    import wheel_pkg::*;

    localparam int N  = 10;
    localparam int PW = 18;
    localparam int VW = 8;
    localparam int DB = 8;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk_in = ~clk_in;

    wheel_state_buffer_if #(.NUM_NODES(N), .POSITION_SIZE(PW),
                            .VELOCITY_SIZE(VW), .DROP_BITS(DB)) bus ();

    wheel_state_buffer #(.NUM_NODES(N), .POSITION_SIZE(PW),
                         .VELOCITY_SIZE(VW), .DROP_BITS(DB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame();
        bus.frame_in = 1'b1;
        tick();
        bus.frame_in = 1'b0;
    endtask

    task automatic do_load();
        for (int i = 0; i < N; i++) begin
            bus.init_nodes_in[IDX_X][i] = PW'(-30 + i);
            bus.init_nodes_in[IDX_Y][i] = PW'(-20 + 2 * i);
        end
        bus.load_in = 1'b1;
        tick();
        bus.load_in = 1'b0;
    endtask

    // Beat i: pos (xb+i, yb-i), vel (vxb+i, vyb-i). Optional result on last cycle.
    task automatic send(input int np, input int nv, input int xb, input int yb,
                        input int vxb, input int vyb, input bit res_last);
        int cyc;
        cyc = (np > nv) ? np : nv;
        for (int i = 0; i < cyc; i++) begin
            bus.node_valid_in = (i < np);
            bus.node_x_in     = PW'(xb + i);
            bus.node_y_in     = PW'(yb - i);
            bus.vel_valid_in  = (i < nv);
            bus.vel_x_in      = VW'(vxb + i);
            bus.vel_y_in      = VW'(vyb - i);
            bus.result_in     = res_last && (i == cyc - 1);
            tick();
        end
        bus.node_valid_in = 1'b0;
        bus.vel_valid_in  = 1'b0;
        bus.result_in     = 1'b0;
    endtask

    task automatic pulse_result();
        bus.result_in = 1'b1;
        tick();
        bus.result_in = 1'b0;
    endtask

    initial begin
        bus.frame_in      = 1'b0;
        bus.load_in       = 1'b0;
        bus.init_nodes_in = '0;
        bus.node_x_in     = '0;
        bus.node_y_in     = '0;
        bus.node_valid_in = 1'b0;
        bus.vel_x_in      = '0;
        bus.vel_y_in      = '0;
        bus.vel_valid_in  = 1'b0;
        bus.result_in     = 1'b0;

        // Reset state
        #3;
        chk("rst_begin",  bus.begin_out, 0);
        chk("rst_commit", bus.commit_out, 0);
        chk("rst_busy",   bus.busy_out, 0);
        chk("rst_error",  bus.error_out, 0);
        chk("rst_drop",   bus.drop_count_out, 0);
        chk("rst_node",   $signed(bus.nodes_out[0][0]), 0);
        tick();
        tick();
        rst_in = 1'b1;

        // 1. Normal update
        do_load();
        chk("ld_n0x", $signed(bus.nodes_out[0][0]), -30);
        chk("ld_n3y", $signed(bus.nodes_out[1][3]), -14);
        chk("ld_v0",  $signed(bus.velocities_out[0][0]), 0);
        pulse_frame();
        chk("t1_begin", bus.begin_out, 1);
        chk("t1_busy",  bus.busy_out, 1);
        tick();
        chk("t1_begin_off", bus.begin_out, 0);
        send(10, 10, -28, -21, 2, -1, 0);
        pulse_result();
        chk("t1_commit_early", bus.commit_out, 0);
        chk("t1_busy_commit",  bus.busy_out, 1);
        chk("t1_n0x_hold",     $signed(bus.nodes_out[0][0]), -30);
        tick();
        chk("t1_commit", bus.commit_out, 1);
        chk("t1_n0x",    $signed(bus.nodes_out[0][0]), -28);
        chk("t1_n0y",    $signed(bus.nodes_out[1][0]), -21);
        chk("t1_v0y",    $signed(bus.velocities_out[1][0]), -1);
        chk("t1_n9y",    $signed(bus.nodes_out[1][9]), -30);
        chk("t1_v9x",    $signed(bus.velocities_out[0][9]), 11);
        chk("t1_error",  bus.error_out, 0);
        chk("t1_idle",   bus.busy_out, 0);
        tick();
        chk("t1_commit_off", bus.commit_out, 0);
        chk("t1_no_begin",   bus.begin_out, 0);

        // 2. Short update
        pulse_frame();
        tick();
        send(9, 10, 100, 200, 20, 30, 0);
        pulse_result();
        chk("t2_commit", bus.commit_out, 0);
        chk("t2_error",  bus.error_out, 1);
        chk("t2_idle",   bus.busy_out, 0);
        tick();
        chk("t2_commit2", bus.commit_out, 0);
        chk("t2_n0x",     $signed(bus.nodes_out[0][0]), -28);
        chk("t2_v0y",     $signed(bus.velocities_out[1][0]), -1);

        // 3a. Overflow (after reset so the sticky error starts clear)
        rst_in = 1'b0;
        tick();
        chk("t3_err_clr", bus.error_out, 0);
        rst_in = 1'b1;
        tick();
        pulse_frame();
        tick();
        send(11, 10, 50, 60, 5, 6, 0);
        pulse_result();
        chk("t3_ovf_commit", bus.commit_out, 0);
        chk("t3_ovf_error",  bus.error_out, 1);
        tick();
        chk("t3_ovf_live", $signed(bus.nodes_out[0][0]), 0);

        // 3b. Last beat in the same cycle as result
        pulse_frame();
        tick();
        send(10, 10, 1000, -1000, -50, 40, 1);
        chk("t3_same_pre",  bus.commit_out, 0);
        tick();
        chk("t3_same_commit", bus.commit_out, 1);
        chk("t3_same_n9x",    $signed(bus.nodes_out[0][9]), 1009);
        chk("t3_same_n9y",    $signed(bus.nodes_out[1][9]), -1009);
        chk("t3_same_v9y",    $signed(bus.velocities_out[1][9]), 31);
        tick();

        // 4. Frames while busy
        pulse_frame();
        chk("t4_begin", bus.begin_out, 1);
        tick();
        pulse_frame();
        tick();
        pulse_frame();
        tick();
        pulse_frame();
        chk("t4_drop", bus.drop_count_out, 2);
        send(10, 10, -5, 5, 1, 2, 1);
        chk("t4_pre_commit", bus.commit_out, 0);
        tick();
        chk("t4_commit",       bus.commit_out, 1);
        chk("t4_begin_hold",   bus.begin_out, 0);
        tick();
        chk("t4_begin_again",  bus.begin_out, 1);
        chk("t4_busy_again",   bus.busy_out, 1);
        chk("t4_drop_kept",    bus.drop_count_out, 2);

        // 5. Load aborts an update
        send(3, 3, 7, 7, 7, 7, 0);
        do_load();
        chk("t5_n0x",  $signed(bus.nodes_out[0][0]), -30);
        chk("t5_n9y",  $signed(bus.nodes_out[1][9]), -2);
        chk("t5_v9x",  $signed(bus.velocities_out[0][9]), 0);
        chk("t5_idle", bus.busy_out, 0);
        pulse_result();
        chk("t5_no_commit_a", bus.commit_out, 0);
        tick();
        chk("t5_no_commit_b", bus.commit_out, 0);
        chk("t5_n0x_kept",    $signed(bus.nodes_out[0][0]), -30);
        chk("t5_err_kept",    bus.error_out, 1);
        chk("t5_drop_kept",   bus.drop_count_out, 2);

        // 5b. Async reset while in COMMIT
        pulse_frame();
        tick();
        send(10, 10, 3, 3, 3, 3, 1);
        chk("t5_in_commit", bus.busy_out, 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("t5_rst_busy",   bus.busy_out, 0);
        chk("t5_rst_commit", bus.commit_out, 0);
        chk("t5_rst_error",  bus.error_out, 0);
        chk("t5_rst_drop",   bus.drop_count_out, 0);
        chk("t5_rst_node",   $signed(bus.nodes_out[0][0]), 0);
        chk("t5_rst_begin",  bus.begin_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
